// File: rtl/bcd_down_timer_if.sv
// Command/status bundle for bcd_down_timer: preset load, run control and
// count/expiry status. The controller drives the master side.
interface bcd_down_timer_if #(
  parameter int unsigned DIGITS = 2
) ();
  logic                LD;
  logic [4*DIGITS-1:0] DIN;
  logic                START;
  logic                STOP;
  logic                EN;
  logic [4*DIGITS-1:0] Q;
  logic                ZERO;
  logic                BUSY;
  logic                DONE;

  modport master (output LD, DIN, START, STOP, EN,
                  input  Q, ZERO, BUSY, DONE);
  modport slave  (input  LD, DIN, START, STOP, EN,
                  output Q, ZERO, BUSY, DONE);
endinterface

// File: rtl/bcd_down_timer.sv
// Loadable cascaded BCD down-counter/timer with one-cycle DONE on expiry
// and optional auto-reload of the preset.
module bcd_down_timer #(
  parameter int unsigned DIGITS      = 2,
  parameter bit          AUTO_RELOAD = 1'b0
) (
  input  logic              CLK,
  input  logic              RB,
  bcd_down_timer_if.slave   bus
);
  localparam int unsigned W = 4 * DIGITS;

  typedef enum logic {IDLE, RUN} state_e;

  state_e         state_q, state_d;
  logic [W-1:0]   q_q, q_d;
  logic [W-1:0]   rl_q, rl_d;
  logic           done_q, done_d;
  logic [W-1:0]   din_clamped;
  logic [W-1:0]   q_dec;
  logic           borrow;
  logic           zero;

  always_ff @(posedge CLK or negedge RB) begin
    if (!RB) begin
      state_q <= IDLE;
      q_q     <= '0;
      rl_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      q_q     <= q_d;
      rl_q    <= rl_d;
      done_q  <= done_d;
    end
  end

  always_comb begin
    din_clamped = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      din_clamped[4*i +: 4] = (bus.DIN[4*i +: 4] > 4'd9) ? 4'd9 : bus.DIN[4*i +: 4];
    end
  end

  // Borrow ripples through every digit in one cycle: 0 wraps to 9 and keeps borrowing.
  always_comb begin
    q_dec  = q_q;
    borrow = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (borrow) begin
        if (q_q[4*i +: 4] == 4'd0) begin
          q_dec[4*i +: 4] = 4'd9;
        end else begin
          q_dec[4*i +: 4] = q_q[4*i +: 4] - 4'd1;
          borrow          = 1'b0;
        end
      end
    end
  end

  always_comb zero = (q_q == '0);

  // Command priority: LD > STOP > START > EN; START only acts from IDLE.
  always_comb begin
    state_d = state_q;
    q_d     = q_q;
    rl_d    = rl_q;
    done_d  = 1'b0;
    if (bus.LD) begin
      q_d     = din_clamped;
      rl_d    = din_clamped;
      state_d = IDLE;
    end else if (bus.STOP) begin
      state_d = IDLE;
    end else if (bus.START && state_q == IDLE) begin
      if (zero) begin
        done_d = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else if (bus.EN && state_q == RUN) begin
      if (!zero) begin
        q_d = q_dec;
        if (q_q == W'(1)) begin
          done_d = 1'b1;
          if (!AUTO_RELOAD) state_d = IDLE;
        end
      end else begin
        // Zero in RUN only occurs with auto-reload: restart from the preset.
        q_d    = rl_q;
        done_d = (rl_q == '0);
      end
    end
  end

  always_comb begin
    bus.Q    = q_q;
    bus.ZERO = zero;
    bus.BUSY = (state_q == RUN);
    bus.DONE = done_q;
  end
endmodule

// File: tb/tb_bcd_down_timer.sv
// Directed bench for bcd_down_timer: 2-digit one-shot, 3-digit one-shot and
// 2-digit auto-reload instances sharing one clock and reset.
module tb_bcd_down_timer;
  logic CLK = 1'b0;
  logic RB  = 1'b0;
  int   vectors = 0;
  int   miscompares = 0;

  always #5 CLK = ~CLK;

  bcd_down_timer_if #(.DIGITS(2)) ifa ();
  bcd_down_timer_if #(.DIGITS(3)) ifb ();
  bcd_down_timer_if #(.DIGITS(2)) ifc ();

  bcd_down_timer #(.DIGITS(2), .AUTO_RELOAD(1'b0)) dut_a (.CLK(CLK), .RB(RB), .bus(ifa));
  bcd_down_timer #(.DIGITS(3), .AUTO_RELOAD(1'b0)) dut_b (.CLK(CLK), .RB(RB), .bus(ifb));
  bcd_down_timer #(.DIGITS(2), .AUTO_RELOAD(1'b1)) dut_c (.CLK(CLK), .RB(RB), .bus(ifc));

  typedef struct {
    logic       ld;
    logic [7:0] din;
    logic       start;
    logic       stop;
    logic       en;
    logic [7:0] q;
    logic       busy;
    logic       done;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(input logic ld, input logic [7:0] din, input logic start,
                              input logic stop, input logic en, input logic [7:0] q,
                              input logic busy, input logic done);
    vec_t v;
    v.ld = ld; v.din = din; v.start = start; v.stop = stop; v.en = en;
    v.q = q; v.busy = busy; v.done = done;
    tbl.push_back(v);
  endfunction

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_a(input string tag, input logic [7:0] q, input logic busy, input logic done);
    chk({tag, ".Q"},    16'(ifa.Q), 16'(q));
    chk({tag, ".BUSY"}, 16'(ifa.BUSY), 16'(busy));
    chk({tag, ".DONE"}, 16'(ifa.DONE), 16'(done));
    chk({tag, ".ZERO"}, 16'(ifa.ZERO), 16'(q == 8'h00));
  endtask

  task automatic drive_a(input logic ld, input logic [7:0] din, input logic start,
                         input logic stop, input logic en);
    ifa.LD = ld; ifa.DIN = din; ifa.START = start; ifa.STOP = stop; ifa.EN = en;
    @(posedge CLK); #1;
  endtask

  task automatic drive_b(input logic ld, input logic [11:0] din, input logic start, input logic en);
    ifb.LD = ld; ifb.DIN = din; ifb.START = start; ifb.STOP = 1'b0; ifb.EN = en;
    @(posedge CLK); #1;
  endtask

  task automatic drive_c(input logic ld, input logic [7:0] din, input logic start, input logic en);
    ifc.LD = ld; ifc.DIN = din; ifc.START = start; ifc.STOP = 1'b0; ifc.EN = en;
    @(posedge CLK); #1;
  endtask

  initial begin
    ifa.LD = 0; ifa.DIN = '0; ifa.START = 0; ifa.STOP = 0; ifa.EN = 0;
    ifb.LD = 0; ifb.DIN = '0; ifb.START = 0; ifb.STOP = 0; ifb.EN = 0;
    ifc.LD = 0; ifc.DIN = '0; ifc.START = 0; ifc.STOP = 0; ifc.EN = 0;

    // Basic count 12 -> 00
    add(1, 8'h12, 0, 0, 0, 8'h12, 0, 0);
    add(0, 8'h00, 1, 0, 1, 8'h12, 1, 0);
    add(0, 8'h00, 0, 0, 1, 8'h11, 1, 0);
    add(0, 8'h00, 0, 0, 1, 8'h10, 1, 0);
    for (int i = 9; i >= 1; i--) add(0, 8'h00, 0, 0, 1, 8'(i), 1, 0);
    add(0, 8'h00, 0, 0, 1, 8'h00, 0, 1);
    add(0, 8'h00, 0, 0, 1, 8'h00, 0, 0);
    // Enable gating, pause and resume
    add(1, 8'h05, 0, 0, 0, 8'h05, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h05, 1, 0);
    add(0, 8'h00, 0, 0, 1, 8'h04, 1, 0);
    add(0, 8'h00, 0, 0, 0, 8'h04, 1, 0);
    add(0, 8'h00, 0, 0, 1, 8'h03, 1, 0);
    add(0, 8'h00, 0, 0, 0, 8'h03, 1, 0);
    add(0, 8'h00, 0, 1, 1, 8'h03, 0, 0);
    add(0, 8'h00, 0, 0, 1, 8'h03, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h03, 1, 0);
    add(0, 8'h00, 0, 0, 1, 8'h02, 1, 0);
    add(0, 8'h00, 0, 0, 1, 8'h01, 1, 0);
    add(0, 8'h00, 0, 0, 1, 8'h00, 0, 1);
    add(0, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    // Priority: LD beats START/EN in RUN
    add(1, 8'h08, 0, 0, 0, 8'h08, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h08, 1, 0);
    add(0, 8'h00, 0, 0, 1, 8'h07, 1, 0);
    add(1, 8'h45, 1, 0, 1, 8'h45, 0, 0);
    // START with EN in IDLE: no decrement
    add(1, 8'h04, 0, 0, 0, 8'h04, 0, 0);
    add(0, 8'h00, 1, 0, 1, 8'h04, 1, 0);
    add(0, 8'h00, 0, 0, 1, 8'h03, 1, 0);
    // START at zero: DONE pulse, stays IDLE
    add(1, 8'h00, 0, 0, 0, 8'h00, 0, 0);
    add(0, 8'h00, 1, 0, 0, 8'h00, 0, 1);
    add(0, 8'h00, 0, 0, 1, 8'h00, 0, 0);
    // Clamp on 2 digits
    add(1, 8'hAF, 0, 0, 0, 8'h99, 0, 0);
    add(1, 8'h3C, 0, 0, 0, 8'h39, 0, 0);

    RB = 1'b0;
    @(posedge CLK); #1;
    chk_a("reset_a", 8'h00, 0, 0);
    chk("reset_b.Q", 16'(ifb.Q), 16'h000);
    chk("reset_c.Q", 16'(ifc.Q), 16'h00);
    #2 RB = 1'b1;

    foreach (tbl[i]) begin
      drive_a(tbl[i].ld, tbl[i].din, tbl[i].start, tbl[i].stop, tbl[i].en);
      chk_a($sformatf("vec%0d", i), tbl[i].q, tbl[i].busy, tbl[i].done);
    end
    drive_a(0, 8'h00, 0, 0, 0);

    // Borrow across three digits and clamp of the middle digit
    drive_b(1, 12'h100, 0, 0);
    chk("b_ld.Q", 16'(ifb.Q), 16'h100);
    drive_b(0, 12'h000, 1, 0);
    chk("b_start.BUSY", 16'(ifb.BUSY), 16'h1);
    drive_b(0, 12'h000, 0, 1);
    chk("b_borrow.Q", 16'(ifb.Q), 16'h099);
    drive_b(0, 12'h000, 0, 1);
    chk("b_dec.Q", 16'(ifb.Q), 16'h098);
    drive_b(1, 12'h1A5, 0, 0);
    chk("b_clamp.Q", 16'(ifb.Q), 16'h195);
    chk("b_clamp.BUSY", 16'(ifb.BUSY), 16'h0);
    drive_b(0, 12'h000, 0, 0);

    // Auto-reload: period of preset+1 EN ticks, BUSY held
    drive_c(1, 8'h02, 0, 0);
    drive_c(0, 8'h00, 1, 0);
    chk("c_start.Q", 16'(ifc.Q), 16'h02);
    begin
      logic [7:0] exp_q[6] = '{8'h01, 8'h00, 8'h02, 8'h01, 8'h00, 8'h02};
      logic       exp_d[6] = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
      for (int k = 0; k < 6; k++) begin
        drive_c(0, 8'h00, 0, 1);
        chk($sformatf("c_ar%0d.Q", k),    16'(ifc.Q), 16'(exp_q[k]));
        chk($sformatf("c_ar%0d.DONE", k), 16'(ifc.DONE), 16'(exp_d[k]));
        chk($sformatf("c_ar%0d.BUSY", k), 16'(ifc.BUSY), 16'h1);
      end
    end
    drive_c(0, 8'h00, 0, 0);
    chk("c_hold.Q", 16'(ifc.Q), 16'h02);
    chk("c_hold.DONE", 16'(ifc.DONE), 16'h0);
    drive_c(1, 8'h00, 0, 0);

    // Asynchronous reset between clock edges at Q=07
    drive_a(1, 8'h09, 0, 0, 0);
    drive_a(0, 8'h00, 1, 0, 0);
    drive_a(0, 8'h00, 0, 0, 1);
    drive_a(0, 8'h00, 0, 0, 1);
    chk_a("pre_rst", 8'h07, 1, 0);
    #2 RB = 1'b0;
    #1;
    chk_a("async_rst", 8'h00, 0, 0);
    @(negedge CLK);
    RB = 1'b1;
    ifa.EN = 1'b1;
    @(posedge CLK); #1;
    chk_a("post_rst_en1", 8'h00, 0, 0);
    drive_a(0, 8'h00, 0, 0, 1);
    chk_a("post_rst_en2", 8'h00, 0, 0);
    drive_a(0, 8'h00, 1, 0, 1);
    chk_a("post_rst_start", 8'h00, 0, 1);
    drive_a(0, 8'h00, 0, 0, 0);
    chk_a("post_rst_idle", 8'h00, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, expected finish before 200000");
    $fatal(1, "timeout");
  end
endmodule
